// File: rtl/vector_multiplier_pkg.sv
// Shared defaults and accumulator sizing for the fixed-point dot-product pipeline.
package vector_multiplier_pkg;

  localparam int DEFAULT_VECTOR_LENGTH        = 16;
  localparam int DEFAULT_FIXED_POINT_LENGTH   = 16;
  localparam int DEFAULT_FIXED_POINT_POSITION = 10;

  // Full-width products plus one growth bit per adder-tree level: the sum can never overflow.
  function automatic int acc_width(input int vector_length, input int fixed_point_length);
    return 2 * fixed_point_length + $clog2(vector_length);
  endfunction

endpackage

// File: rtl/vector_multiplier_adder_tree.sv
// Pipelined binary adder tree: one register stage per level, inputs zero-padded to a power of 2.
module adder_tree #(
  parameter int N_INPUTS = 16,
  parameter int IN_W     = 32,
  parameter int OUT_W    = 36
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_INPUTS*IN_W-1:0]    data_in,
  output logic signed [OUT_W-1:0]     sum_out
);

  localparam int LEVELS = $clog2(N_INPUTS);
  localparam int P      = 1 << LEVELS;

  // Heap layout: node k has children 2k+1 and 2k+2; indices >= P-1 refer to leaves.
  logic signed [OUT_W-1:0] leaf   [P];
  logic signed [OUT_W-1:0] node_q [P-1];

  for (genvar i = 0; i < P; i++) begin : g_leaf
    if (i < N_INPUTS) begin : g_real
      assign leaf[i] = {{(OUT_W-IN_W){data_in[i*IN_W+IN_W-1]}}, data_in[i*IN_W +: IN_W]};
    end else begin : g_pad
      assign leaf[i] = '0;
    end
  end

  for (genvar k = 0; k < P-1; k++) begin : g_node
    logic signed [OUT_W-1:0] lhs;
    logic signed [OUT_W-1:0] rhs;

    if (2*k+1 >= P-1) begin : g_lhs_leaf
      assign lhs = leaf[2*k+1-(P-1)];
    end else begin : g_lhs_node
      assign lhs = node_q[2*k+1];
    end

    if (2*k+2 >= P-1) begin : g_rhs_leaf
      assign rhs = leaf[2*k+2-(P-1)];
    end else begin : g_rhs_node
      assign rhs = node_q[2*k+2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) node_q[k] <= '0;
      else        node_q[k] <= lhs + rhs;
    end
  end

  assign sum_out = node_q[0];

endmodule

// File: rtl/vector_multiplier.sv
// Pipelined signed fixed-point dot product; define VECTOR_MULTIPLIER_SATURATE_EN to clamp instead of wrap.
module vector_multiplier
  import vector_multiplier_pkg::*;
#(
  parameter int VECTOR_LENGTH        = DEFAULT_VECTOR_LENGTH,
  parameter int FIXED_POINT_LENGTH   = DEFAULT_FIXED_POINT_LENGTH,
  parameter int FIXED_POINT_POSITION = DEFAULT_FIXED_POINT_POSITION
) (
  input  logic                                        clk_in,
  input  logic                                        reset_i,
  input  logic                                        valid_in,
  input  logic [VECTOR_LENGTH*FIXED_POINT_LENGTH-1:0] vector_1_in,
  input  logic [VECTOR_LENGTH*FIXED_POINT_LENGTH-1:0] vector_2_in,
  output logic [FIXED_POINT_LENGTH-1:0]               product_out,
  output logic                                        valid_out
);

  localparam int W       = FIXED_POINT_LENGTH;
  localparam int PW      = 2 * W;
  localparam int ACC_W   = acc_width(VECTOR_LENGTH, FIXED_POINT_LENGTH);
  localparam int LATENCY = 2 + $clog2(VECTOR_LENGTH);

  // Handshake: valid_in qualifies the operand pair in the cycle it is high; there is no ready,
  // so a pair is accepted every cycle. valid_out qualifies product_out for exactly that cycle.

  logic [VECTOR_LENGTH*PW-1:0] prod_d;
  logic [VECTOR_LENGTH*PW-1:0] prod_q;
  logic signed [ACC_W-1:0]     tree_sum;
  logic signed [ACC_W-1:0]     shifted;
  logic [W-1:0]                result_d;
  logic [LATENCY-1:0]          valid_sr;

  always_comb begin
    prod_d = '0;
    for (int i = 0; i < VECTOR_LENGTH; i++) begin
      prod_d[i*PW +: PW] = PW'($signed(vector_1_in[i*W +: W]) * $signed(vector_2_in[i*W +: W]));
    end
  end

  always_ff @(posedge clk_in or negedge reset_i) begin
    if (!reset_i) prod_q <= '0;
    else          prod_q <= prod_d;
  end

  adder_tree #(
    .N_INPUTS (VECTOR_LENGTH),
    .IN_W     (PW),
    .OUT_W    (ACC_W)
  ) u_adder_tree (
    .clk     (clk_in),
    .rst_n   (reset_i),
    .data_in (prod_q),
    .sum_out (tree_sum)
  );

  // Arithmetic shift floors toward negative infinity; no rounding term is added.
  assign shifted = tree_sum >>> FIXED_POINT_POSITION;

`ifdef VECTOR_MULTIPLIER_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

  always_comb begin
    result_d = shifted[W-1:0];
    if (shifted > SAT_MAX)      result_d = SAT_MAX[W-1:0];
    else if (shifted < SAT_MIN) result_d = SAT_MIN[W-1:0];
  end
`else
  always_comb begin
    result_d = shifted[W-1:0];
  end
`endif

  always_ff @(posedge clk_in or negedge reset_i) begin
    if (!reset_i) begin
      product_out <= '0;
      valid_sr    <= '0;
    end else begin
      product_out <= result_d;
      valid_sr    <= {valid_sr[LATENCY-2:0], valid_in};
    end
  end

  assign valid_out = valid_sr[LATENCY-1];

endmodule

// File: tb/tb_vector_multiplier.sv
// Directed bench for vector_multiplier at default parameters; expectations follow VECTOR_MULTIPLIER_SATURATE_EN.
module tb_vector_multiplier;

  localparam int VL  = 16;
  localparam int W   = 16;
  localparam int LAT = 6;

  logic              clk_in;
  logic              reset_i;
  logic              valid_in;
  logic [VL*W-1:0]   vector_1_in;
  logic [VL*W-1:0]   vector_2_in;
  logic [W-1:0]      product_out;
  logic              valid_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  int           stamp_q[$];

  vector_multiplier dut (
    .clk_in      (clk_in),
    .reset_i     (reset_i),
    .valid_in    (valid_in),
    .vector_1_in (vector_1_in),
    .vector_2_in (vector_2_in),
    .product_out (product_out),
    .valid_out   (valid_out)
  );

  // clock / reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [VL*W-1:0] fill(input logic [W-1:0] v);
    return {VL{v}};
  endfunction

  function automatic logic [VL*W-1:0] elem0(input logic [W-1:0] v);
    logic [VL*W-1:0] r;
    r = '0;
    r[W-1:0] = v;
    return r;
  endfunction

  // drivers
  task automatic send(input logic [VL*W-1:0] a, input logic [VL*W-1:0] b, input logic [W-1:0] exp);
    @(negedge clk_in);
    vector_1_in = a;
    vector_2_in = b;
    valid_in    = 1'b1;
    exp_q.push_back(exp);
    stamp_q.push_back(cyc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk_in);
    valid_in = 1'b0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // scoreboard monitor
  always @(negedge clk_in) begin
    if (reset_i && valid_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", valid_out, 1'b0);
      end else begin
        check("product", product_out, exp_q.pop_front());
        check("latency", cyc - stamp_q.pop_front(), LAT);
      end
    end
  end

  initial begin
    logic [VL*W-1:0] a;
    logic [VL*W-1:0] b;

    reset_i     = 1'b0;
    valid_in    = 1'b0;
    vector_1_in = '0;
    vector_2_in = '0;
    #1;
    check("reset_product", product_out, 16'h0000);
    check("reset_valid", valid_out, 1'b0);
    repeat (3) @(negedge clk_in);
    reset_i = 1'b1;

    // 1.0 * 1.0 summed 16 times
    send(fill(16'h0400), fill(16'h0400), 16'h4000);
    drain();

    // 0.5 * -2.0
    send(elem0(16'h0200), elem0(16'hF800), 16'hFC00);
    drain();

    // floor truncation of tiny results
    send(elem0(16'hFFFF), elem0(16'h0001), 16'hFFFF);
    send(elem0(16'h0001), elem0(16'h0001), 16'h0000);
    drain();

    // overflow of the output format
`ifdef VECTOR_MULTIPLIER_SATURATE_EN
    send(fill(16'h2000), fill(16'h2000), 16'h7FFF);
    send(fill(16'h2000), fill(16'hE000), 16'h8000);
`else
    send(fill(16'h2000), fill(16'h2000), 16'h0000);
    send(fill(16'h2000), fill(16'hE000), 16'h0000);
`endif
    drain();

    // 8 back-to-back: A0=k*1.0 times B0=1.0, plus A1=1.0 times B1=-1.0 => (k-1)*1.0
    for (int k = 1; k <= 8; k++) begin
      a = '0;
      b = '0;
      a[W-1:0]   = 16'(k * 16'h0400);
      b[W-1:0]   = 16'h0400;
      a[2*W-1:W] = 16'h0400;
      b[2*W-1:W] = 16'hFC00;
      send(a, b, 16'((k - 1) * 16'h0400));
    end
    drain();

    // same stream, reset while results are still in flight
    for (int k = 1; k <= 8; k++) begin
      a = '0;
      b = '0;
      a[W-1:0]   = 16'(k * 16'h0400);
      b[W-1:0]   = 16'h0400;
      a[2*W-1:W] = 16'h0400;
      b[2*W-1:W] = 16'hFC00;
      send(a, b, 16'((k - 1) * 16'h0400));
    end
    @(negedge clk_in);
    valid_in = 1'b0;
    #2;
    reset_i = 1'b0;
    exp_q.delete();
    stamp_q.delete();
    #1;
    check("midreset_product", product_out, 16'h0000);
    check("midreset_valid", valid_out, 1'b0);
    repeat (2) @(negedge clk_in);
    reset_i = 1'b1;
    repeat (12) @(negedge clk_in);
    check("post_reset_queue", exp_q.size(), 0);

    // first pair after reset arrives with normal latency
    send(fill(16'h0400), elem0(16'h0C00), 16'h0C00);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/vector_multiplier.md
VECTOR_MULTIPLIER -- requirements
Module: vector_multiplier

Interface
REQ-001 The module SHALL have parameter VECTOR_LENGTH, default 16, number of elements per vector (legal range 2..64).
REQ-002 The module SHALL have parameter FIXED_POINT_LENGTH, default 16, width of each signed fixed-point element and of the result.
REQ-003 The module SHALL have parameter FIXED_POINT_POSITION, default 10, number of fractional bits (Q6.10 at defaults; legal range 0..FIXED_POINT_LENGTH-1).
REQ-004 The module SHALL have a port clk_in  input  1  single clock; all state updates on its rising edge.
REQ-005 The module SHALL have a port reset_i  input  1  reset, asynchronous, active-low.
REQ-006 The module SHALL have a port valid_in  input  1  vector_1_in/vector_2_in hold a valid operand pair this cycle.
REQ-007 The module SHALL have a port vector_1_in  input  VECTOR_LENGTH*FIXED_POINT_LENGTH  packed operand A; element i at bits [i*FIXED_POINT_LENGTH +: FIXED_POINT_LENGTH].
REQ-008 The module SHALL have a port vector_2_in  input  VECTOR_LENGTH*FIXED_POINT_LENGTH  packed operand B, same packing.
REQ-009 The module SHALL have a port product_out  output  FIXED_POINT_LENGTH  signed fixed-point dot product, same format as elements.
REQ-010 The module SHALL have a port valid_out  output  1  product_out holds the result of a valid_in operand pair.

Function
REQ-011 The module SHALL compute product_out = sum over i of A[i]*B[i], all operands two's-complement signed.
REQ-012 The module SHALL register all VECTOR_LENGTH full-width products (2*FIXED_POINT_LENGTH bits) in stage 1.
REQ-013 The module SHALL sum products in a binary adder tree with one register stage per level; non-power-of-2 lengths are zero-padded to the next power of 2.
REQ-014 The module SHALL keep the accumulator at 2*FIXED_POINT_LENGTH+clog2(VECTOR_LENGTH) bits so no intermediate overflow occurs.
REQ-015 The module SHALL rescale the sum by arithmetic right shift of FIXED_POINT_POSITION bits (truncation toward negative infinity, no rounding) and register it into product_out.
REQ-016 The module SHALL have latency L = 2 + clog2(VECTOR_LENGTH) cycles from a valid_in sample to the matching valid_out (6 at defaults).
REQ-017 The module SHALL accept a new operand pair every cycle (full throughput); there is no backpressure.
REQ-018 The module SHALL propagate valid_in through an L-deep shift register alongside the data; valid_out follows it exactly.
REQ-019 The module SHALL still compute data when valid_in is low; product_out is only meaningful when valid_out is high.

Reset
REQ-020 The module SHALL, while reset_i is low, asynchronously clear all pipeline registers, product_out to 0 and valid_out to 0.
REQ-021 The module SHALL discard all in-flight operands on reset mid-operation; the first valid_out after release comes L cycles after the first post-reset valid_in.

Configuration
REQ-022 The module SHALL, when VECTOR_MULTIPLIER_SATURATE_EN is defined, clamp the rescaled sum to the signed FIXED_POINT_LENGTH range (max 0x7FFF, min 0x8000 at defaults).
REQ-023 The module SHALL, when VECTOR_MULTIPLIER_SATURATE_EN is not defined, output the low FIXED_POINT_LENGTH bits of the rescaled sum (wrap-around).

Structure
REQ-024 The module SHALL take default parameter values and an accumulator-width function from a shared package vector_multiplier_pkg.
REQ-025 The module SHALL implement the pipelined summation in one sub-module named adder_tree, parameterised by input count and width.

Verification (defaults, 1.0 = 0x0400)
REQ-026 The bench SHALL apply all A[i]=B[i]=0x0400 with valid_in=1 -> product_out 0x4000, valid_out high exactly 6 cycles later.
REQ-027 The bench SHALL apply A[0]=0x0200 (0.5), B[0]=0xF800 (-2.0), other elements 0 -> product_out 0xFC00 (-1.0).
REQ-028 The bench SHALL apply A[0]=0xFFFF, B[0]=0x0001, other elements 0 -> product_out 0xFFFF (floor truncation); A[0]=B[0]=0x0001 -> 0x0000.
REQ-029 The bench SHALL apply all A[i]=B[i]=0x2000 (8.0) -> 0x7FFF with VECTOR_MULTIPLIER_SATURATE_EN, 0x0000 without; all A[i]=0x2000, B[i]=0xE000 -> 0x8000 with the macro.
REQ-030 The bench SHALL stream 8 back-to-back valid pairs -> 8 consecutive correct results; reset_i pulsed low mid-stream -> product_out=0, valid_out=0 immediately, no stale results afterwards.
